// File: rtl/spi_capture_pkg.sv
// Shared state type and default timing constants for spi_sample_capture.
package spi_capture_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, QUIET} capture_state_t;

  localparam int FRAME_BITS_DEF   = 16;
  localparam int DATA_BITS_DEF    = 12;
  localparam int SCLK_DIV_DEF     = 2;
  localparam int CS_SETUP_DEF     = 1;
  localparam int QUIET_CYCLES_DEF = 4;

  // Edge (counted from the accepted start edge) at which a frame completes.
  function automatic int frame_done_edge(input int cs_setup, input int sclk_div,
                                         input int frame_bits);
    return cs_setup + 2 * sclk_div * frame_bits;
  endfunction

  localparam int FRAME_DONE_EDGE = frame_done_edge(CS_SETUP_DEF, SCLK_DIV_DEF, FRAME_BITS_DEF);

endpackage

// File: rtl/spi_sample_capture.sv
// SPI receive engine: one CS_b/sclk frame per start pulse, sample out on valid/ready.
// Optional macro SPI_CAPTURE_LEAD_CHECK_EN adds the sticky frame_err output.
module spi_sample_capture
  import spi_capture_pkg::*;
#(
  parameter int FRAME_BITS   = FRAME_BITS_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF,
  parameter int SCLK_DIV     = SCLK_DIV_DEF,
  parameter int CS_SETUP     = CS_SETUP_DEF,
  parameter int QUIET_CYCLES = QUIET_CYCLES_DEF
) (
  input  logic                 clk8,
  input  logic                 PRESETn,
  input  logic                 enable,
  input  logic                 start,
  input  logic                 MISO,
  output logic                 CS_b,
  output logic                 sclk,
  output logic                 busy,
  output logic [DATA_BITS-1:0] sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  input  logic                 overrun_clr
`ifdef SPI_CAPTURE_LEAD_CHECK_EN
  ,output logic                frame_err
`endif
);

  localparam int CNT_W  = 16;
  localparam int BCNT_W = $clog2(FRAME_BITS + 1);
`ifdef SPI_CAPTURE_LEAD_CHECK_EN
  localparam int SHIFT_W = FRAME_BITS;
`else
  // Only the payload is kept; leading bits fall off the top of the register.
  localparam int SHIFT_W = DATA_BITS;
`endif

  capture_state_t      state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BCNT_W-1:0]   bcnt_q;
  logic [SHIFT_W-1:0]  shift_q;
  logic                phase_end;
  logic                frame_done;

  always_ff @(posedge clk8 or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q times SETUP, each sclk half-period, and QUIET.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    phase_end  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && enable) begin
          state_d = SETUP;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (!enable) begin
          state_d = QUIET;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(CS_SETUP - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (!enable) begin
          state_d = QUIET;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(SCLK_DIV - 1)) begin
          phase_end = 1'b1;
          cnt_d     = '0;
          if (sclk && bcnt_q == BCNT_W'(FRAME_BITS - 1)) begin
            frame_done = 1'b1;
            state_d    = QUIET;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      QUIET: begin
        if (cnt_q == CNT_W'(QUIET_CYCLES - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Serial interface driven from the next state so CS_b/sclk change on the deciding edge.
  always_ff @(posedge clk8 or negedge PRESETn) begin
    if (!PRESETn) begin
      CS_b   <= 1'b1;
      sclk   <= 1'b0;
      bcnt_q <= '0;
    end else begin
      CS_b <= !(state_d == SETUP || state_d == SHIFT);
      if (state_d != SHIFT) begin
        sclk <= 1'b0;
      end else if (phase_end) begin
        sclk <= ~sclk;
      end
      if (state_q != SHIFT) begin
        bcnt_q <= '0;
      end else if (phase_end && sclk) begin
        bcnt_q <= bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk8 or negedge PRESETn) begin
    if (!PRESETn) begin
      shift_q      <= '0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      if (phase_end && !sclk) begin
        shift_q <= {shift_q[SHIFT_W-2:0], MISO};
      end
      if (frame_done) begin
        sample_data  <= shift_q[DATA_BITS-1:0];
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (frame_done && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

`ifdef SPI_CAPTURE_LEAD_CHECK_EN
  logic lead_err;
  assign lead_err = |shift_q[SHIFT_W-1:DATA_BITS];

  always_ff @(posedge clk8 or negedge PRESETn) begin
    if (!PRESETn) begin
      frame_err <= 1'b0;
    end else if (frame_done && lead_err) begin
      frame_err <= 1'b1;
    end else if (overrun_clr) begin
      frame_err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_spi_sample_capture.sv
// Bench for spi_sample_capture: SPI slave model, frame-level reference model,
// a vector table of whole frames, directed corner sequences and a random soak.
module tb_spi_sample_capture;
  import spi_capture_pkg::*;

  localparam int FB = FRAME_BITS_DEF;
  localparam int DB = DATA_BITS_DEF;
  localparam int D  = FRAME_DONE_EDGE;

  logic clk8 = 1'b0;
  logic PRESETn = 1'b1;
  logic enable = 1'b1;
  logic start = 1'b0;
  logic MISO;
  logic CS_b, sclk, busy;
  logic [DB-1:0] sample_data;
  logic sample_valid;
  logic sample_ready = 1'b1;
  logic overrun;
  logic overrun_clr = 1'b0;
`ifdef SPI_CAPTURE_LEAD_CHECK_EN
  logic frame_err;
`endif

  always #5 clk8 = ~clk8;

  spi_sample_capture dut (
    .clk8(clk8), .PRESETn(PRESETn), .enable(enable), .start(start), .MISO(MISO),
    .CS_b(CS_b), .sclk(sclk), .busy(busy), .sample_data(sample_data),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .overrun(overrun),
    .overrun_clr(overrun_clr)
`ifdef SPI_CAPTURE_LEAD_CHECK_EN
    , .frame_err(frame_err)
`endif
  );

  // SPI slave: presents word MSB-first, advancing after each observed sclk rise.
  logic [FB-1:0] slave_word = '0;
  int   rises = 0;
  logic sclk_d = 1'b0;
  always @(negedge clk8) begin
    if (CS_b) rises <= 0;
    else if (sclk && !sclk_d) rises <= rises + 1;
    sclk_d <= sclk;
  end
  assign MISO = (rises < FB) ? slave_word[FB-1-rises] : 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model in frame terms: edge numbers relative to the accepted start edge.
  int edge_no = 0;
  logic m_busy = 0, m_run = 0, m_sclk = 0, m_valid = 0, m_ovr = 0, m_ferr = 0;
  logic [DB-1:0] m_data = '0;
  logic [FB-1:0] m_word = '0;
  int m_s = 0, m_idle_edge = 0;
  logic rand_mode = 0;
  int cs_falls = 0;
  logic prev_cs = 1'b1;

  task automatic model_reset();
    m_busy = 0; m_run = 0; m_sclk = 0; m_valid = 0; m_ovr = 0; m_ferr = 0; m_data = '0;
  endtask

  task automatic model_edge();
    logic deliver, oset, fset;
    int off;
    deliver = 0; oset = 0; fset = 0;
    if (!m_busy) begin
      if (start && enable) begin
        m_busy = 1; m_run = 1; m_s = edge_no; m_word = slave_word;
      end
    end else if (m_run) begin
      if (!enable) begin
        m_run = 0; m_idle_edge = edge_no + QUIET_CYCLES_DEF;
      end else if (edge_no == m_s + D) begin
        deliver = 1; m_run = 0; m_idle_edge = edge_no + QUIET_CYCLES_DEF;
      end
    end else if (edge_no == m_idle_edge) begin
      m_busy = 0;
    end
    m_sclk = 0;
    if (m_run) begin
      off = edge_no - m_s - CS_SETUP_DEF - SCLK_DIV_DEF;
      if (off >= 0 && (off % (2 * SCLK_DIV_DEF)) < SCLK_DIV_DEF) m_sclk = 1;
    end
    if (deliver) begin
      if (m_valid && !sample_ready) oset = 1;
      fset = |m_word[FB-1:DB];
      m_valid = 1;
      m_data = m_word[DB-1:0];
    end else if (m_valid && sample_ready) begin
      m_valid = 0;
    end
    if (oset) m_ovr = 1;
    else if (overrun_clr) m_ovr = 0;
    if (fset) m_ferr = 1;
    else if (overrun_clr) m_ferr = 0;
    edge_no++;
  endtask

  task automatic compare_all();
    logic [31:0] act, exp;
    act = 32'({CS_b, sclk, busy, sample_valid, overrun, sample_data});
    exp = 32'({!m_run, m_sclk, m_busy, m_valid, m_ovr, m_data});
`ifdef SPI_CAPTURE_LEAD_CHECK_EN
    act[31] = frame_err;
    exp[31] = m_ferr;
`endif
    check("edge_model", act, exp);
    if (prev_cs && !CS_b) cs_falls++;
    prev_cs = CS_b;
  endtask

  task automatic step();
    if (rand_mode && CS_b) slave_word = FB'($urandom);
    model_edge();
    @(posedge clk8);
    @(negedge clk8);
    compare_all();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    start = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input logic [FB-1:0] word, input logic rdy_run, input logic rdy_done,
                           input logic clr_start, input logic clr_done,
                           output logic [DB-1:0] dat, output logic v_done,
                           output logic v_next, output logic ovr);
    slave_word = word;
    start = 1; sample_ready = rdy_run; overrun_clr = clr_start;
    step();
    start = 0; overrun_clr = 0;
    for (int e = 1; e < D; e++) step();
    sample_ready = rdy_done; overrun_clr = clr_done;
    step();
    dat = sample_data; v_done = sample_valid; ovr = overrun;
    overrun_clr = 0;
    step();
    v_next = sample_valid;
    wait_idle();
  endtask

  typedef struct {
    logic [FB-1:0] word;
    logic rdy_run, rdy_done, clr_start, clr_done;
    logic [DB-1:0] exp_data;
    logic exp_v_done, exp_v_next, exp_ovr;
  } vec_t;
  vec_t tbl[7];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    logic [DB-1:0] dat;
    logic vd, vn, ov;

    tbl[0] = '{16'h0ABC, 1'b1, 1'b1, 1'b0, 1'b0, 12'hABC, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{16'hF123, 1'b1, 1'b1, 1'b0, 1'b0, 12'h123, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{16'h0123, 1'b0, 1'b0, 1'b0, 1'b0, 12'h123, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{16'h0456, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{16'h0555, 1'b0, 1'b0, 1'b1, 1'b1, 12'h555, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{16'h0FFF, 1'b0, 1'b1, 1'b1, 1'b0, 12'hFFF, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{16'h7000, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 1'b0};

    // Reset values
    #1 PRESETn = 1'b0;
    repeat (3) @(negedge clk8);
    check("rst_cs_b", 32'(CS_b), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    PRESETn = 1'b1;
    model_reset();
    step();

    // Whole-frame vector table
    for (int i = 0; i < 7; i++) begin
      run_frame(tbl[i].word, tbl[i].rdy_run, tbl[i].rdy_done, tbl[i].clr_start,
                tbl[i].clr_done, dat, vd, vn, ov);
      check($sformatf("tbl%0d_data", i), 32'(dat), 32'(tbl[i].exp_data));
      check($sformatf("tbl%0d_valid_done", i), 32'(vd), 32'(tbl[i].exp_v_done));
      check($sformatf("tbl%0d_valid_next", i), 32'(vn), 32'(tbl[i].exp_v_next));
      check($sformatf("tbl%0d_overrun", i), 32'(ov), 32'(tbl[i].exp_ovr));
    end

    // Start while busy is ignored; start on the first IDLE edge is taken
    sample_ready = 1; cs_falls = 0;
    slave_word = 16'h0DEF;
    start = 1; step(); start = 0;
    for (int e = 1; e < 20; e++) step();
    start = 1; step(); start = 0;
    wait_idle();
    check("busy_start_cs_falls", 32'(cs_falls), 32'd1);
    check("busy_start_data", 32'(sample_data), 32'h0DEF);
    slave_word = 16'h0789;
    start = 1; step(); start = 0;
    check("restart_cs_low", 32'(CS_b), 32'd0);
    for (int e = 1; e <= D; e++) step();
    check("restart_data", 32'(sample_data), 32'h0789);
    wait_idle();

    // Abort by enable at edge 30
    slave_word = 16'h0321;
    start = 1; step(); start = 0;
    for (int e = 1; e < 30; e++) step();
    enable = 0; step();
    check("abort_cs_b", 32'(CS_b), 32'd1);
    check("abort_sclk", 32'(sclk), 32'd0);
    enable = 1;
    wait_idle();
    check("abort_no_valid", 32'(sample_valid), 32'd0);
    check("abort_data_kept", 32'(sample_data), 32'h0789);
    run_frame(16'h0654, 1'b1, 1'b1, 1'b0, 1'b0, dat, vd, vn, ov);
    check("after_abort_data", 32'(dat), 32'h0654);

    // Random soak against the model
    rand_mode = 1;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 5) == 0);
      enable = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) sample_ready = ~sample_ready;
      overrun_clr = ($urandom_range(0, 29) == 0);
      step();
    end
    rand_mode = 0; enable = 1; overrun_clr = 0; sample_ready = 1;
    wait_idle();

`ifdef SPI_CAPTURE_LEAD_CHECK_EN
    // Leading-bit check
    overrun_clr = 1; step(); overrun_clr = 0;
    check("ferr_cleared", 32'(frame_err), 32'd0);
    run_frame(16'h8ABC, 1'b1, 1'b1, 1'b0, 1'b0, dat, vd, vn, ov);
    check("ferr_data", 32'(dat), 32'hABC);
    check("ferr_set", 32'(frame_err), 32'd1);
    run_frame(16'h0ABC, 1'b1, 1'b1, 1'b0, 1'b0, dat, vd, vn, ov);
    check("ferr_sticky", 32'(frame_err), 32'd1);
    overrun_clr = 1; step(); overrun_clr = 0;
    check("ferr_clr", 32'(frame_err), 32'd0);
`endif

    // Reset asserted mid-frame at edge 40
    run_frame(16'h0246, 1'b0, 1'b0, 1'b0, 1'b0, dat, vd, vn, ov);
    check("pre_reset_valid", 32'(sample_valid), 32'd1);
    slave_word = 16'h0FFF;
    start = 1; step(); start = 0;
    for (int e = 1; e < 40; e++) step();
    @(posedge clk8);
    #1 PRESETn = 1'b0;
    #1;
    check("midrst_cs_b", 32'(CS_b), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_valid", 32'(sample_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_data", 32'(sample_data), 32'd0);
    model_reset();
    @(negedge clk8);
    @(negedge clk8);
    PRESETn = 1'b1;
    sample_ready = 1'b0;
    for (int e = 0; e < 80; e++) step();
    check("post_rst_no_sample", 32'(sample_valid), 32'd0);
    check("post_rst_cs_b", 32'(CS_b), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_sample_capture.md
Name: spi_sample_capture

Overview:
- SPI receive engine that runs one ADC/microphone frame per `start` pulse: drops CS_b, generates sclk, shifts in MISO and presents the sample on a valid/ready interface.
- Sits between the sample-rate divider (drives `start`) and the sample queue (consumes `sample_data`).
- Runs entirely in the clk8 domain.

Parameters:
- FRAME_BITS, 16, sclk rising edges per frame.
- DATA_BITS, 12, right-justified payload bits kept (DATA_BITS <= FRAME_BITS).
- SCLK_DIV, 2, clk8 cycles per sclk half-period (>= 1).
- CS_SETUP, 1, clk8 cycles from CS_b fall to the start of the first sclk low phase (>= 1).
- QUIET_CYCLES, 4, minimum clk8 cycles with CS_b high between frames (>= 1).

Ports:
- clk8  input  1  capture clock
- PRESETn  input  1  reset
- enable  input  1  capture enable; low aborts or blocks frames
- start  input  1  single-cycle frame request
- MISO  input  1  serial data from converter
- CS_b  output  1  chip select, active low
- sclk  output  1  serial clock, idle low (CPOL=0)
- busy  output  1  high in any state other than IDLE
- sample_data  output  DATA_BITS  captured sample
- sample_valid  output  1  sample_data holds an unconsumed sample
- sample_ready  input  1  consumer accepts sample when high with sample_valid
- overrun  output  1  sticky: an unconsumed sample was overwritten
- overrun_clr  input  1  clears overrun

Behaviour:
- Clocking/reset: one clock, clk8; reset PRESETn is asynchronous, active-low.
- Reset values: CS_b=1, sclk=0, busy=0, sample_data=0, sample_valid=0, overrun=0, state IDLE, all counters 0.
- States:
  - IDLE: `start & enable` sampled at edge 0 -> SETUP, CS_b=0.
  - SETUP: CS_SETUP cycles -> SHIFT.
  - SHIFT: per bit, sclk low SCLK_DIV cycles then high SCLK_DIV cycles. MISO is shifted in MSB-first at the same edge that drives sclk high. The last high phase ends at edge CS_SETUP+2*SCLK_DIV*FRAME_BITS (65 with defaults). At that edge: sclk=0, CS_b=1, sample_data=shift[DATA_BITS-1:0], sample_valid=1 -> QUIET.
  - QUIET: CS_b high for QUIET_CYCLES -> IDLE.
- Timing: the k-th sclk rise (k=1..FRAME_BITS) is at edge CS_SETUP+SCLK_DIV+(k-1)*2*SCLK_DIV, giving edges 3, 7, ..., 63 with defaults.
- Ignored `start`: any start outside IDLE (busy=1) is ignored, with no queuing.
- Abort: enable low in SETUP or SHIFT -> next edge CS_b=1, sclk=0 -> QUIET. No sample is produced and sample_valid/sample_data are untouched.
- Handshake:
  - sample_valid & sample_ready at an edge -> sample_valid=0 at that edge.
  - sample_data is stable while sample_valid=1.
  - Frame completes with valid=1 and ready=0 -> new data overwrites, valid stays 1, overrun=1.
  - Frame completes with valid=1 and ready=1 at the same edge -> new data loaded, valid stays 1, no overrun.
- overrun: cleared by overrun_clr. A set and a clear at the same edge -> set wins.
- Leading bits: the FRAME_BITS-DATA_BITS leading bits are discarded.
- Reset asserted mid-frame: immediate return to reset values. CS_b rises asynchronously.

Optional Feature:
- Macro SPI_CAPTURE_LEAD_CHECK_EN.
- Defined:
  - Adds output `frame_err` (1 bit, sticky, reset 0).
  - Set when any of the leading FRAME_BITS-DATA_BITS captured bits is 1 at frame completion.
  - Cleared by overrun_clr; set wins.
  - The sample is still delivered.
- Undefined: no port, leading bits ignored.

Decomposition:
- Package spi_capture_pkg:
  - enum capture_state_t {IDLE, SETUP, SHIFT, QUIET}.
  - Default parameter constants.
  - localparam for the frame-completion edge count.
- No sub-module; the half-period counter and bit counter are inline.

Test Plan:
- Basic frame: MISO drives 16-bit pattern 0x0ABC MSB-first, start at edge 0, ready held 1 -> CS_b low edges 1-65, sclk rises at 3, 7, ..., 63, sample_data=0xABC with 1-cycle sample_valid after edge 65, busy low after QUIET.
- Backpressure: ready=0, two frames 0x0123 then 0x0456 -> sample_valid stays 1, sample_data=0x456, overrun=1. overrun_clr -> 0. Then ready=1 -> valid drops.
- Start while busy: start pulses at edges 0 and 20 -> exactly one frame, CS_b toggles once. Start at the first IDLE edge after QUIET -> second frame begins.
- Abort: enable drops at edge 30 -> CS_b=1, sclk=0 after edge 30, no sample_valid, next frame after QUIET_CYCLES captures correctly.
- Reset mid-frame: PRESETn low at edge 40 -> CS_b=1, sclk=0, valid=0 immediately, no spurious sample after release.
- With SPI_CAPTURE_LEAD_CHECK_EN: frame 0x8ABC -> sample_data=0xABC, frame_err=1. Frame 0x0ABC afterward -> frame_err stays 1 until cleared.
